// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit: load/store initiator for the 32-bit datamem port;       |
// | 64-bit accesses go out as two word beats. Option macro: MISALIGN_TRAP_EN |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int MEM_WORDS = 65536,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_double_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic        mem_enable_o,
  output logic        mem_readwrite_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [62:0] C_WORDS    = 63'(MEM_WORDS);
  localparam logic [1:0]  C_LAT_LAST = 2'(RD_LAT - 1);

  state_t      state_q;
  logic        req_ready_q, resp_valid_q, resp_err_q;
  logic        mem_enable_q, mem_rw_q;
  logic [63:0] resp_rdata_q, mem_addr_q, mem_wdata_q, wdata_q;
  logic        write_q, double_q, beat_q;
  logic [61:0] idx_q;
  logic [31:0] lo_q;
  logic [1:0]  cnt_q;

  logic [61:0] idx_d;
  logic        oob_d, mis_d, err_d, last_beat_d;
  logic [63:0] b1_addr_d;

  assign idx_d = req_addr_i[63:2];
  // Widened by one bit so W+1 cannot wrap below the limit.
  assign oob_d = ({1'b0, idx_d} >= C_WORDS) ||
                 (req_double_i && (({1'b0, idx_d} + 63'd1) >= C_WORDS));
`ifdef MISALIGN_TRAP_EN
  assign mis_d = req_double_i ? (req_addr_i[2:0] != 3'd0) : (req_addr_i[1:0] != 2'd0);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];
  assign mis_d = 1'b0;
`endif
  assign err_d       = oob_d | mis_d;
  assign last_beat_d = !double_q || beat_q;
  assign b1_addr_d   = {2'b00, idx_q + 62'd1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
      mem_enable_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 64'd0;
      write_q      <= 1'b0;
      double_q     <= 1'b0;
      beat_q       <= 1'b0;
      idx_q        <= 62'd0;
      wdata_q      <= 64'd0;
      lo_q         <= 32'd0;
      cnt_q        <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write_i;
            double_q    <= req_double_i;
            idx_q       <= idx_d;
            wdata_q     <= req_wdata_i;
            beat_q      <= 1'b0;
            lo_q        <= 32'd0;
            cnt_q       <= 2'd0;
            if (err_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 64'd0;
            end else begin
              state_q      <= S_ISSUE;
              mem_enable_q <= 1'b1;
              mem_rw_q     <= req_write_i;
              mem_addr_q   <= {2'b00, idx_d};
              mem_wdata_q  <= req_write_i ? {32'd0, req_wdata_i[31:0]} : 64'd0;
            end
          end
        end
        S_ISSUE: begin
          mem_enable_q <= 1'b0;
          mem_rw_q     <= 1'b0;
          mem_addr_q   <= 64'd0;
          mem_wdata_q  <= 64'd0;
          if (!write_q) begin
            state_q <= S_WAIT;
            cnt_q   <= 2'd0;
          end else if (!last_beat_d) begin
            beat_q       <= 1'b1;
            mem_enable_q <= 1'b1;
            mem_rw_q     <= 1'b1;
            mem_addr_q   <= b1_addr_d;
            mem_wdata_q  <= {32'd0, wdata_q[63:32]};
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= 64'd0;
          end
        end
        S_WAIT: begin
          if (cnt_q == C_LAT_LAST) begin
            if (!last_beat_d) begin
              lo_q         <= mem_rdata_i;
              beat_q       <= 1'b1;
              state_q      <= S_ISSUE;
              mem_enable_q <= 1'b1;
              mem_rw_q     <= 1'b0;
              mem_addr_q   <= b1_addr_d;
              mem_wdata_q  <= 64'd0;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= beat_q ? {mem_rdata_i, lo_q} : {32'd0, mem_rdata_i};
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 64'd0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o     = req_ready_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_err_o      = resp_err_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign mem_enable_o    = mem_enable_q;
  assign mem_readwrite_o = mem_rw_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_unit: scoreboard bench with a word-array memory model.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;
  localparam int MEM_WORDS = 65536;
  localparam int RD_LAT    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_double = 1'b0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [63:0] resp_rdata, mem_addr, mem_wdata;
  logic        mem_enable, mem_readwrite;
  logic [31:0] mem_rdata;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_double_i(req_double),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_enable_o(mem_enable), .mem_readwrite_o(mem_readwrite),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic err; logic [63:0] rdata; int lat; int acc; } exp_t;
  typedef struct { logic [63:0] addr; logic rw; logic [31:0] data; } beat_t;

  exp_t        exp_q[$];
  beat_t       beat_q[$];
  logic [31:0] ref_mem [logic [63:0]];
  logic [31:0] dmem    [logic [63:0]];
  logic [31:0] pipe    [RD_LAT];
  int          n_tests = 0, n_fail = 0, cyc = 0, rr_mode = 2;
  logic        seen = 1'b0, chk_after = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_ref(input logic [63:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'd0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Datamem model: writes commit on the enable edge, reads appear RD_LAT-1 edges later.
  always @(posedge clk) begin
    logic [31:0] rv;
    beat_t       b;
    rv = $urandom;
    if (mem_enable) begin
      n_tests++;
      if (beat_q.size() == 0) begin
        n_fail++;
        $display("FAIL enable_without_beat: got addr %h expected no access", mem_addr);
      end else begin
        b = beat_q.pop_front();
        check("beat_addr", mem_addr, b.addr);
        check("beat_rw", 64'(mem_readwrite), 64'(b.rw));
        check("beat_wdata", mem_wdata, b.rw ? {32'd0, b.data} : 64'd0);
      end
      if (mem_readwrite) dmem[mem_addr] = mem_wdata[31:0];
      else rv = dmem.exists(mem_addr) ? dmem[mem_addr] : 32'd0;
    end else if (!rst && cyc > 2) begin
      check("idle_mem_pins", mem_addr | mem_wdata | 64'(mem_readwrite), 64'd0);
    end
    pipe[0] <= rv;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       resp_ready = ($urandom_range(0, 3) != 0);
      1:       resp_ready = 1'b0;
      default: resp_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on each accepted response.
  always @(negedge clk) begin
    exp_t e;
    if (chk_after) begin
      check("req_ready_after_resp", 64'(req_ready), 64'd1);
      check("resp_single_cycle", 64'(resp_valid), 64'd0);
      chk_after = 1'b0;
    end else if (resp_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
      end else begin
        e = exp_q[0];
        if (!seen) begin
          check("latency", 64'(cyc - e.acc), 64'(e.lat));
          seen = 1'b1;
        end
        check("resp_err", 64'(resp_err), 64'(e.err));
        check("resp_rdata", resp_rdata, e.rdata);
        check("req_ready_in_resp", 64'(req_ready), 64'd0);
        if (resp_ready) begin
          void'(exp_q.pop_front());
          seen      = 1'b0;
          chk_after = 1'b1;
          check("beats_done", 64'(beat_q.size()), 64'd0);
        end
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("req_ready_timeout", 64'(req_ready), 64'd1);
  endtask

  task automatic push_beat(input logic [63:0] a, input logic rw, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.rw = rw; b.data = d;
    beat_q.push_back(b);
  endtask

  task automatic issue(input logic w, input logic d, input logic [63:0] a, input logic [63:0] wd);
    exp_t        e;
    logic [63:0] wi;
    logic        err;
    wait_ready();
    wi  = a >> 2;
    err = (wi >= 64'(MEM_WORDS)) || (d && (wi + 64'd1 >= 64'(MEM_WORDS)));
`ifdef MISALIGN_TRAP_EN
    if (d ? (a[2:0] != 3'd0) : (a[1:0] != 2'd0)) err = 1'b1;
`endif
    e.err = err; e.acc = cyc; e.rdata = 64'd0;
    if (err) e.lat = 1;
    else begin
      push_beat(wi, w, wd[31:0]);
      if (d) push_beat(wi + 64'd1, w, wd[63:32]);
      if (w) begin
        ref_mem[wi] = wd[31:0];
        if (d) ref_mem[wi + 64'd1] = wd[63:32];
        e.lat = d ? 3 : 2;
      end else begin
        e.rdata = d ? {rd_ref(wi + 64'd1), rd_ref(wi)} : {32'd0, rd_ref(wi)};
        e.lat   = d ? 2 * RD_LAT + 3 : RD_LAT + 2;
      end
    end
    exp_q.push_back(e);
    req_write = w; req_double = d; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = $urandom;
    req_double = $urandom;
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
  endtask

  initial begin
    logic [63:0] wi, a;
    int          k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_mem_enable", 64'(mem_enable), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    rst = 1'b0;

    issue(1'b1, 1'b0, 64'h10, 64'hDEADBEEF);
    issue(1'b0, 1'b0, 64'h10, 64'd0);
    issue(1'b1, 1'b1, 64'h20, 64'h1122334455667788);
    issue(1'b0, 1'b1, 64'h20, 64'd0);
    issue(1'b0, 1'b0, 64'h40000, 64'd0);
    issue(1'b0, 1'b1, 64'h3FFFC, 64'd0);
    issue(1'b1, 1'b1, 64'h3FFF8, 64'h0BADF00D_12345678);
    issue(1'b0, 1'b1, 64'h3FFF8, 64'd0);
    issue(1'b0, 1'b0, 64'h12, 64'd0);
    issue(1'b1, 1'b0, 64'h34, 64'hCAFEF00D);

    // Reset lands on the edge that commits beat 0 of a double store.
    wait_ready();
    push_beat(64'd12, 1'b1, 32'h5A5A5A5A);
    req_write = 1'b1; req_double = 1'b1; req_addr = 64'h30;
    req_wdata = 64'hA5A5A5A5_5A5A5A5A; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_beat0_enable", 64'(mem_enable), 64'd1);
    rst = 1'b1;
    ref_mem[64'd12] = 32'h5A5A5A5A;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    check("abort_mem_enable", 64'(mem_enable), 64'd0);
    check("abort_beats_left", 64'(beat_q.size()), 64'd0);
    beat_q.delete();
    issue(1'b0, 1'b1, 64'h30, 64'd0);

    // Backpressure hold then release.
    wait_ready();
    rr_mode = 1;
    issue(1'b0, 1'b0, 64'h10, 64'd0);
    k = 0;
    while (!resp_valid && k < 50) begin @(negedge clk); k++; end
    check("bp_resp_arrives", 64'(resp_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_resp_held", 64'(resp_valid), 64'd1);
    end
    rr_mode = 2;

    rr_mode = 0;
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      if (k < 7)      wi = 64'($urandom_range(0, 63));
      else if (k < 9) wi = 64'($urandom_range(65532, 65537));
      else            wi = {$urandom, $urandom} >> 2;
      a = (wi << 2) | (($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : 64'd0);
      issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, {$urandom, $urandom});
    end
    for (int i = 0; i < 32; i++) issue(1'b0, 1'b1, 64'(i * 8), 64'd0);

    k = 0;
    while ((exp_q.size() != 0 || !req_ready) && k < 500) begin @(negedge clk); k++; end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
